// File: rtl/cmd_pkg.sv
// Shared definitions for the OPB command link (cmd_client / cmd_server):
// frame constants, response error codes, FSM states and frame byte selection.
package cmd_pkg;

    localparam logic [7:0] HDR_WR    = 8'h5A;
    localparam logic [7:0] HDR_RD    = 8'h5B;
    localparam int         FRAME_LEN = 10;
    localparam logic [3:0] LAST_IDX  = 4'(FRAME_LEN - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_FORMAT  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RECV,
        ST_DONE
    } state_t;

    // Byte at position idx of a frame: header, address MSB first,
    // data MSB first, then the inverted header as trailer.
    function automatic logic [7:0] frame_byte(
        input logic [7:0]  hdr,
        input logic [31:0] addr,
        input logic [31:0] data,
        input logic [3:0]  idx
    );
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            4'd0: b = hdr;
            4'd1: b = addr[31:24];
            4'd2: b = addr[23:16];
            4'd3: b = addr[15:8];
            4'd4: b = addr[7:0];
            4'd5: b = data[31:24];
            4'd6: b = data[23:16];
            4'd7: b = data[15:8];
            4'd8: b = data[7:0];
            4'd9: b = ~hdr;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cmd_client_timer.sv
// Reply timeout timer: synchronises the 2 kHz time base, turns each rising
// edge into a one-cycle tick and counts ticks up to TIMEOUT_TICKS.
module cmd_client_timer #(
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic pulse_2khz,
    input  logic run,
    input  logic clear,
    output logic timeout
);

    // TIMEOUT_TICKS must be at least 1 so the counter has a width.
    localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic             sync_1;
    logic             sync_2;
    logic             sync_prev;
    logic             tick;
    logic [CNT_W-1:0] tick_cnt;

    // Two-flop synchroniser plus one delay flop for edge detection.
    always_ff @(posedge sys_clk) begin
        // NOTE: non-blocking assignments make each flop take its neighbour's pre-edge value, forming a real shift chain.
        if (sys_rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= pulse_2khz;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign tick    = sync_2 & ~sync_prev;
    assign timeout = (tick_cnt == CNT_W'(TIMEOUT_TICKS));

    // Tick counter: clear wins over counting; saturates at the timeout value.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt <= '0;
        end else if (clear) begin
            tick_cnt <= '0;
        end else if (run && tick && !timeout) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_client.sv
// OPB command client: serialises one read/write request into a 10-byte
// frame on the TX byte stream, then collects the 10-byte reply from the RX
// stream and reports data plus an ok / timeout / format-error code.
module cmd_client
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        pulse_2khz,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic [7:0]  tx_data,
    output logic        tx_stb,
    input  logic        tx_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_stb,
    output logic        rx_ack
);

    state_t      state;
    logic [3:0]  idx;
    logic [7:0]  hdr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rx_addr_q;
    logic [31:0] rx_data_q;
    logic        timeout;
    logic        in_recv;

    // RX bytes are drained in every state but DONE; in RECV they are parsed,
    // elsewhere they are simply dropped.
    assign rx_ack  = rx_stb && !sys_rst && (state != ST_DONE);
    assign in_recv = (state == ST_RECV);

    // Counter is held at zero outside RECV, so it starts clean on entry,
    // and restarts on every consumed reply byte.
    cmd_client_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pulse_2khz(pulse_2khz),
        .run       (in_recv),
        .clear     (!in_recv || rx_stb),
        .timeout   (timeout)
    );

    // Request / frame / reply state machine with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= ST_IDLE;
            idx       <= 4'd0;
            hdr_q     <= 8'h00;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rx_addr_q <= 32'h0;
            rx_data_q <= 32'h0;
            req_ready <= 1'b1;
            tx_stb    <= 1'b0;
            tx_data   <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= ERR_OK;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        hdr_q     <= req_wr ? HDR_WR : HDR_RD;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wr ? req_wdata : 32'h0;
                        idx       <= 4'd0;
                        tx_stb    <= 1'b1;
                        tx_data   <= req_wr ? HDR_WR : HDR_RD;
                        req_ready <= 1'b0;
                        state     <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_ack) begin
                        if (idx == LAST_IDX) begin
                            tx_stb  <= 1'b0;
                            tx_data <= 8'h00;
                            idx     <= 4'd0;
                            state   <= ST_RECV;
                        end else begin
                            idx     <= idx + 4'd1;
                            tx_data <= frame_byte(hdr_q, addr_q, wdata_q, idx + 4'd1);
                        end
                    end
                end

                ST_RECV: begin
                    // A received byte takes priority over a simultaneous timeout.
                    if (rx_stb) begin
                        if (idx == 4'd0) begin
                            // Hunt for our own header; anything else is line noise.
                            if (rx_data == hdr_q) begin
                                idx <= 4'd1;
                            end
                        end else begin
                            if (idx <= 4'd4) begin
                                rx_addr_q <= {rx_addr_q[23:0], rx_data};
                            end else if (idx <= 4'd8) begin
                                rx_data_q <= {rx_data_q[23:0], rx_data};
                            end
                            if (idx == LAST_IDX) begin
                                rsp_valid <= 1'b1;
                                rsp_rdata <= rx_data_q;
                                rsp_err   <= ((rx_addr_q != addr_q) || (rx_data != ~hdr_q))
                                             ? ERR_FORMAT : ERR_OK;
                                idx       <= 4'd0;
                                state     <= ST_DONE;
                            end else begin
                                idx <= idx + 4'd1;
                            end
                        end
                    end else if (timeout) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= ERR_TIMEOUT;
                        idx       <= 4'd0;
                        state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_client.sv
// Scoreboard bench for cmd_client: expected TX bytes and responses are queued
// when a request/reply is driven and compared as the DUT produces them.
module tb_cmd_client;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        pulse_2khz;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic [7:0]  tx_data;
    logic        tx_stb;
    logic        tx_ack;
    logic [7:0]  rx_data;
    logic        rx_stb;
    logic        rx_ack;

    cmd_client #(
        .TIMEOUT_TICKS(3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .pulse_2khz(pulse_2khz),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx_data   (tx_data),
        .tx_stb    (tx_stb),
        .tx_ack    (tx_ack),
        .rx_data   (rx_data),
        .rx_stb    (rx_stb),
        .rx_ack    (rx_ack)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    logic [7:0]  tx_q[$];
    logic [33:0] rsp_q[$];
    logic [7:0]  rx_bytes[$];

    bit accepted;
    bit pulse_en;
    int pulse_div;
    int pulse_edges;
    int edge3_cyc;
    int rsp_cyc;
    int edges_at_rsp;

    // One clock: sample this cycle's handshakes just after inputs settle,
    // score them, advance the time base, then move to the next falling edge.
    task automatic cycle();
        logic [7:0]  eb;
        logic [33:0] er;
        #1;
        accepted = req_valid && req_ready;
        if (tx_stb && tx_ack) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected got=%02h want=no_byte", tx_data);
            end else begin
                eb = tx_q.pop_front();
                if (tx_data !== eb) begin
                    errors++;
                    $display("FAIL tx_byte got=%02h want=%02h", tx_data, eb);
                end
            end
        end
        if (rsp_valid) begin
            rsp_cyc      = cyc_n;
            edges_at_rsp = pulse_edges;
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got err=%b data=%08h want=no_rsp", rsp_err, rsp_rdata);
            end else begin
                er = rsp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== er) begin
                    errors++;
                    $display("FAIL rsp got err=%b data=%08h want err=%b data=%08h",
                             rsp_err, rsp_rdata, er[33:32], er[31:0]);
                end
            end
        end
        if (pulse_en) begin
            pulse_div++;
            if (pulse_div == 10) begin
                pulse_div  = 0;
                pulse_2khz = ~pulse_2khz;
                if (pulse_2khz) begin
                    pulse_edges++;
                    if (pulse_edges == 3) edge3_cyc = cyc_n;
                end
            end
        end
        cyc_n++;
        @(negedge sys_clk);
    endtask

    // Present a request until accepted and queue the frame it should produce.
    task automatic send_request(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        logic [7:0]  hdr;
        logic [31:0] d;
        int n;
        hdr = wr ? 8'h5A : 8'h5B;
        d   = wr ? wdata : 32'h0;
        tx_q.push_back(hdr);
        for (int i = 3; i >= 0; i--) tx_q.push_back(addr[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) tx_q.push_back(d[i*8 +: 8]);
        tx_q.push_back(~hdr);
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 20) begin
            cycle();
            n++;
        end
        req_valid = 1'b0;
        checks++;
        if (!accepted) begin
            errors++;
            $display("FAIL req_accept got=not_accepted want=accepted");
        end
    endtask

    task automatic wait_tx_done();
        int n = 0;
        while (tx_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL tx_done got=%0d_bytes_left want=0", tx_q.size());
            tx_q.delete();
        end
    endtask

    // Stream rx_bytes back-to-back, checking each one is acknowledged.
    task automatic send_reply();
        foreach (rx_bytes[i]) begin
            rx_stb  = 1'b1;
            rx_data = rx_bytes[i];
            #1;
            checks++;
            if (rx_ack !== 1'b1) begin
                errors++;
                $display("FAIL rx_ack byte=%0d got=%b want=1", i, rx_ack);
            end
            cycle();
        end
        rx_stb = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (rsp_q.size() != 0 && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("FAIL rsp_wait got=%0d_pending want=0", rsp_q.size());
            rsp_q.delete();
        end
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        rx_stb  = 1'b1;
        repeat (3) cycle();
        checks++; if (req_ready !== 1'b1)    begin errors++; $display("FAIL rst_req_ready got=%b want=1", req_ready); end
        checks++; if (tx_stb !== 1'b0)       begin errors++; $display("FAIL rst_tx_stb got=%b want=0", tx_stb); end
        checks++; if (tx_data !== 8'h00)     begin errors++; $display("FAIL rst_tx_data got=%02h want=00", tx_data); end
        checks++; if (rx_ack !== 1'b0)       begin errors++; $display("FAIL rst_rx_ack got=%b want=0", rx_ack); end
        checks++; if (rsp_valid !== 1'b0)    begin errors++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0)   begin errors++; $display("FAIL rst_rsp_rdata got=%08h want=0", rsp_rdata); end
        checks++; if (rsp_err !== 2'b00)     begin errors++; $display("FAIL rst_rsp_err got=%b want=00", rsp_err); end
        sys_rst = 1'b0;
        cycle();
        // Idle state drains stray RX bytes.
        #1;
        checks++; if (rx_ack !== 1'b1)       begin errors++; $display("FAIL idle_rx_ack got=%b want=1", rx_ack); end
        cycle();
        rx_stb = 1'b0;
        cycle();
    endtask

    task automatic test_write_loopback();
        send_request(1'b1, 32'hAABBCCDD, 32'h11223344);
        checks++; if (tx_stb !== 1'b1)    begin errors++; $display("FAIL hdr_next_cycle got=%b want=1", tx_stb); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b want=0", req_ready); end
        // A request while busy must be ignored and must not disturb the frame.
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'hFFFFFFFF;
        req_wdata = 32'hFFFFFFFF;
        repeat (3) begin
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ignored got=%b want=0", req_ready); end
            cycle();
        end
        req_valid = 1'b0;
        wait_tx_done();
        rsp_q.push_back({2'b00, 32'h11223344});
        rx_bytes = '{8'h5A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
        send_reply();
        wait_rsp();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL back_to_idle got=%b want=1", req_ready); end
        repeat (2) cycle();
    endtask

    task automatic test_read();
        checks++;
        if (rsp_rdata !== 32'h11223344 || rsp_err !== 2'b00) begin
            errors++;
            $display("FAIL rsp_held got err=%b data=%08h want err=00 data=11223344", rsp_err, rsp_rdata);
        end
        send_request(1'b0, 32'h12345678, 32'hCAFECAFE);
        wait_tx_done();
        rsp_q.push_back({2'b00, 32'hAABBCCDD});
        rx_bytes = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA4};
        send_reply();
        wait_rsp();
        repeat (2) cycle();
    endtask

    task automatic test_resync();
        send_request(1'b0, 32'h12345678, 32'h0);
        wait_tx_done();
        rsp_q.push_back({2'b00, 32'hDEADBEEF});
        rx_bytes = '{8'h00, 8'hFF, 8'h5A, 8'h5B, 8'h12, 8'h34, 8'h56, 8'h78,
                     8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA4};
        send_reply();
        wait_rsp();
        repeat (2) cycle();
    endtask

    task automatic test_format_error();
        // Wrong trailer on a read.
        send_request(1'b0, 32'h12345678, 32'h0);
        wait_tx_done();
        rsp_q.push_back({2'b10, 32'hAABBCCDD});
        rx_bytes = '{8'h5B, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA5};
        send_reply();
        wait_rsp();
        repeat (2) cycle();
        // Echoed address differs in its last byte.
        send_request(1'b1, 32'h01020304, 32'h55667788);
        wait_tx_done();
        rsp_q.push_back({2'b10, 32'h55667788});
        rx_bytes = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h05, 8'h55, 8'h66, 8'h77, 8'h88, 8'hA5};
        send_reply();
        wait_rsp();
        repeat (2) cycle();
    endtask

    task automatic test_timeout();
        send_request(1'b0, 32'h00000040, 32'h0);
        wait_tx_done();
        rsp_q.push_back({2'b01, 32'h0});
        pulse_edges  = 0;
        pulse_div    = 0;
        edge3_cyc    = -1000;
        rsp_cyc      = -1;
        edges_at_rsp = -1;
        pulse_en     = 1'b1;
        wait_rsp();
        pulse_en   = 1'b0;
        pulse_2khz = 1'b0;
        checks++;
        if (edges_at_rsp != 3) begin
            errors++;
            $display("FAIL timeout_edges got=%0d want=3", edges_at_rsp);
        end
        checks++;
        if (rsp_cyc - edge3_cyc < 2 || rsp_cyc - edge3_cyc > 8) begin
            errors++;
            $display("FAIL timeout_latency got=%0d want=2..8", rsp_cyc - edge3_cyc);
        end
        repeat (4) cycle();
    endtask

    task automatic test_stall_and_reset();
        logic [7:0] stall_byte;
        int n;
        send_request(1'b1, 32'hCAFEF00D, 32'h0BADBEEF);
        n = 0;
        while (tx_q.size() > 6 && n < 50) begin
            cycle();
            n++;
        end
        tx_ack     = 1'b0;
        stall_byte = tx_q[0];
        repeat (50) begin
            checks++;
            if (tx_stb !== 1'b1 || tx_data !== stall_byte || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL tx_stall got stb=%b data=%02h ready=%b want stb=1 data=%02h ready=0",
                         tx_stb, tx_data, req_ready, stall_byte);
            end
            cycle();
        end
        tx_ack = 1'b1;
        wait_tx_done();
        // Partial reply, then reset in the middle of RECV.
        rx_bytes = '{8'h5A, 8'hCA, 8'hFE};
        send_reply();
        rsp_cyc = -1;
        sys_rst = 1'b1;
        repeat (2) cycle();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || tx_stb !== 1'b0) begin
            errors++;
            $display("FAIL recv_reset got ready=%b rsp_valid=%b tx_stb=%b want 1 0 0",
                     req_ready, rsp_valid, tx_stb);
        end
        sys_rst = 1'b0;
        repeat (30) cycle();
        checks++;
        if (rsp_cyc != -1) begin
            errors++;
            $display("FAIL recv_reset_rsp got=rsp_at_%0d want=none", rsp_cyc);
        end
        // Reset while a TX byte is waiting for its ACK withdraws the strobe.
        send_request(1'b0, 32'h00000001, 32'h0);
        repeat (2) cycle();
        tx_ack = 1'b0;
        cycle();
        checks++;
        if (tx_stb !== 1'b1) begin
            errors++;
            $display("FAIL tx_pending got=%b want=1", tx_stb);
        end
        sys_rst = 1'b1;
        cycle();
        checks++;
        if (tx_stb !== 1'b0 || tx_data !== 8'h00 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL tx_reset got stb=%b data=%02h ready=%b want 0 00 1", tx_stb, tx_data, req_ready);
        end
        sys_rst = 1'b0;
        tx_ack  = 1'b1;
        tx_q.delete();
        repeat (5) cycle();
    endtask

    initial begin
        sys_rst    = 1'b1;
        pulse_2khz = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        tx_ack     = 1'b1;
        rx_data    = 8'h00;
        rx_stb     = 1'b0;
        pulse_en   = 1'b0;
        pulse_div  = 0;
        pulse_edges = 0;
        edge3_cyc  = 0;
        rsp_cyc    = -1;
        edges_at_rsp = -1;
        @(negedge sys_clk);
        test_reset();
        test_write_loopback();
        test_read();
        test_resync();
        test_format_error();
        test_timeout();
        test_stall_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cmd_client.md
CMD_CLIENT -- requirements
Module: cmd_client

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 20, number of 2 kHz ticks (10 ms) allowed between reply bytes before abort.
REQ-002 SYS_CLK  in  1  single clock, 100 MHz; all logic rising-edge.
REQ-003 SYS_RST  in  1  reset, synchronous, active-high.
REQ-004 PULSE_2KHZ  in  1  2 kHz square wave, used as the timeout time base.
REQ-005 REQ_VALID  in  1  a command request is present.
REQ-006 REQ_READY  out  1  client idle; request accepted when REQ_VALID and REQ_READY are both high.
REQ-007 REQ_WR  in  1  1 = OPB write command, 0 = OPB read command.
REQ-008 REQ_ADDR  in  32  target OPB address.
REQ-009 REQ_WDATA  in  32  write data; sent as zero for reads.
REQ-010 RSP_VALID  out  1  one-cycle pulse; the reply is complete or aborted.
REQ-011 RSP_RDATA  out  32  data field of the reply; held until the next RSP_VALID.
REQ-012 RSP_ERR  out  2  00 ok, 01 timeout, 10 format error; held with RSP_RDATA.
REQ-013 TX_DATA / TX_STB / TX_ACK  out 8 / out 1 / in 1  byte stream to cmn_uart.
REQ-014 RX_DATA / RX_STB / RX_ACK  in 8 / in 1 / out 1  byte stream from cmn_uart.

Function
REQ-015 Frame layout: 10 bytes, sent in this order: header, ADDR[31:24] down to ADDR[7:0], DATA[31:24] down to DATA[7:0], trailer.
REQ-016 Header SHALL be 0x5A for a write and 0x5B for a read; the trailer SHALL be the bitwise inverse of the header (0xA5 / 0xA4).
REQ-017 Stream handshake: a byte transfers on the cycle where STB and ACK are both high; TX_STB and TX_DATA SHALL stay stable until TX_ACK.
REQ-018 FSM states: IDLE, SEND, RECV, DONE; REQ_READY is high only in IDLE.
REQ-019 In IDLE, an accepted request latches the header, address and data; TX_STB with the header byte SHALL rise on the next cycle.
REQ-020 In SEND, each TX_ACK advances a 4-bit byte index; the ACK of byte 9 moves the FSM to RECV with the index cleared.
REQ-021 In RECV, RX_ACK = RX_STB; a byte is consumed on every cycle where RX_STB is high.
REQ-022 In RECV at index 0, a byte that differs from the sent header SHALL be discarded and the index stays 0 (resynchronisation).
REQ-023 Bytes 1-9 are stored; after byte 9 the FSM enters DONE.
REQ-024 In DONE, for one cycle: RSP_VALID=1; RSP_RDATA = received data field; RSP_ERR=10 if the echoed address differs from REQ_ADDR or the trailer differs from ~header, else 00; then return to IDLE.
REQ-025 PULSE_2KHZ SHALL be synchronised by two flops and rising-edge detected; each edge is one tick.
REQ-026 The tick counter clears on entry to RECV and on every consumed RX byte, and counts ticks only while in RECV.
REQ-027 When the counter reaches TIMEOUT_TICKS, the FSM SHALL enter DONE with RSP_ERR=01 and RSP_RDATA=0.
REQ-028 If a byte and the timeout occur in the same cycle, the byte wins.
REQ-029 In IDLE and SEND, RX bytes SHALL be acknowledged and discarded (RX_ACK = RX_STB).
REQ-030 REQ_VALID while busy is ignored; the request is not queued.

Reset
REQ-031 SYS_RST SHALL force IDLE, index and counter 0, and the synchroniser flops 0.
REQ-032 Reset values: REQ_READY=1, TX_STB=0, TX_DATA=0, RX_ACK=0, RSP_VALID=0, RSP_RDATA=0, RSP_ERR=00.
REQ-033 Reset mid-frame SHALL abort without RSP_VALID; a partial TX byte is withdrawn.

Structure
REQ-034 A shared package cmd_pkg SHALL hold: HDR_WR=0x5A, HDR_RD=0x5B, FRAME_LEN=10, the RSP_ERR codes, and the FSM state enum; cmd_server uses the same package.
REQ-035 One sub-module, cmd_client_timer (synchroniser, edge detect, tick counter, timeout flag), SHALL be instantiated; everything else stays in cmd_client.

Verification
REQ-036 Write request ADDR=0xAABBCCDD, WDATA=0x11223344, TX_ACK always high -> TX bytes 5A AA BB CC DD 11 22 33 44 A5; loop-back echo -> RSP_ERR=00, RSP_RDATA=0x11223344.
REQ-037 Read request ADDR=0x12345678 -> TX 5B 12 34 56 78 00 00 00 00 A4; reply 5B 12 34 56 78 AA BB CC DD A4 -> RSP_RDATA=0xAABBCCDD, RSP_ERR=00.
REQ-038 Reply preceded by the garbage bytes 00 FF 5A -> garbage discarded, correct response; reply with trailer 0xA5 for a read -> RSP_ERR=10.
REQ-039 No reply sent, TIMEOUT_TICKS=3 -> RSP_VALID on the 3rd tick edge after RECV entry, RSP_ERR=01, RSP_RDATA=0.
REQ-040 TX_ACK withheld for 50 cycles at byte 4 -> TX_DATA stable throughout, REQ_READY low; SYS_RST asserted mid-RECV -> REQ_READY=1, no RSP_VALID.
